// File: rtl/oled_text_engine.sv
// rtl/oled_text_engine.sv - character framebuffer with dirty-page OLED renderer
//
// Holds PAGES x COLS character codes and re-renders only the pages whose dirty bit
// is set. Each page is sent as the command bytes 22/page/00/10 followed by
// COLS*FONT_W font bytes fetched from an external font ROM.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   en_i                     rendering enable (current page always completes)
//   full_refresh_i           pulse: mark every page dirty
//   invert_i                 XOR data bytes with 8'hFF, sampled once per page
//   wr_en_i/wr_page_i/wr_col_i/wr_data_i   framebuffer write port
//   rom_en_o/rom_addr_o/rom_data_i         font ROM, address {code, column}, 1-cycle latency
//   spi_en_o/spi_data_o/spi_fin_i/dc_o     byte request handshake to SPI controller
//   busy_o                   engine not idle
//   frame_done_o             pulse when the last dirty page completes
module oled_text_engine #(
  parameter int PAGES  = 4,
  parameter int COLS   = 16,
  parameter int FONT_W = 8,
  parameter int CODE_W = 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 en_i,
  input  logic                                 full_refresh_i,
  input  logic                                 invert_i,
  input  logic                                 wr_en_i,
  input  logic [$clog2(PAGES)-1:0]             wr_page_i,
  input  logic [$clog2(COLS)-1:0]              wr_col_i,
  input  logic [CODE_W-1:0]                    wr_data_i,
  output logic                                 rom_en_o,
  output logic [CODE_W+$clog2(FONT_W)-1:0]     rom_addr_o,
  input  logic [7:0]                           rom_data_i,
  output logic                                 spi_en_o,
  output logic [7:0]                           spi_data_o,
  input  logic                                 spi_fin_i,
  output logic                                 dc_o,
  output logic                                 busy_o,
  output logic                                 frame_done_o
);

  localparam int PW = $clog2(PAGES);
  localparam int CW = $clog2(COLS);
  localparam int FW = $clog2(FONT_W);
  localparam int AW = CODE_W + FW;
  localparam logic [FW-1:0] LAST_CLM = FW'(FONT_W - 1);
  localparam logic [CW-1:0] LAST_IND = CW'(COLS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SCAN, S_CMD, S_CMD_WAIT, S_FETCH,
    S_ROM_WAIT, S_DATA, S_DATA_WAIT, S_GAP, S_NEXT
  } state_e;

  state_e              state_q, state_d;
  state_e              ret_q, ret_d;
  logic [PW-1:0]       page_q, page_d;
  logic [1:0]          cmd_q, cmd_d;
  logic [CW-1:0]       ind_q, ind_d;
  logic [FW-1:0]       clm_q, clm_d;
  logic                inv_q, inv_d;
  logic                spi_en_q, spi_en_d;
  logic [7:0]          spi_data_q, spi_data_d;
  logic                dc_q, dc_d;
  logic                rom_en_q, rom_en_d;
  logic [AW-1:0]       rom_addr_q, rom_addr_d;
  logic                frame_done_q, frame_done_d;
  logic [PAGES-1:0]    dirty_q, dirty_d;
  logic [CODE_W-1:0]   fb_q [PAGES][COLS];

  logic                wr_ok;
  logic [PW-1:0]       scan_page;

  // Indices are only out of range when PAGES or COLS is not a power of two.
  assign wr_ok = wr_en_i && (int'(wr_page_i) < PAGES) && (int'(wr_col_i) < COLS);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < PAGES; p++) begin
        for (int c = 0; c < COLS; c++) begin
          fb_q[p][c] <= '0;
        end
      end
    end else if (wr_ok) begin
      fb_q[wr_page_i][wr_col_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      ret_q        <= S_CMD;
      page_q       <= '0;
      cmd_q        <= '0;
      ind_q        <= '0;
      clm_q        <= '0;
      inv_q        <= 1'b0;
      spi_en_q     <= 1'b0;
      spi_data_q   <= '0;
      dc_q         <= 1'b1;
      rom_en_q     <= 1'b0;
      rom_addr_q   <= '0;
      frame_done_q <= 1'b0;
      dirty_q      <= '1;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      page_q       <= page_d;
      cmd_q        <= cmd_d;
      ind_q        <= ind_d;
      clm_q        <= clm_d;
      inv_q        <= inv_d;
      spi_en_q     <= spi_en_d;
      spi_data_q   <= spi_data_d;
      dc_q         <= dc_d;
      rom_en_q     <= rom_en_d;
      rom_addr_q   <= rom_addr_d;
      frame_done_q <= frame_done_d;
      dirty_q      <= dirty_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    page_d       = page_q;
    cmd_d        = cmd_q;
    ind_d        = ind_q;
    clm_d        = clm_q;
    inv_d        = inv_q;
    spi_en_d     = spi_en_q;
    spi_data_d   = spi_data_q;
    dc_d         = dc_q;
    rom_en_d     = 1'b0;
    rom_addr_d   = rom_addr_q;
    frame_done_d = 1'b0;
    dirty_d      = dirty_q;

    // Descending scan so the lowest dirty index is the one left standing.
    scan_page = '0;
    for (int p = PAGES - 1; p >= 0; p--) begin
      if (dirty_q[p]) scan_page = PW'(p);
    end

    case (state_q)
      S_IDLE: begin
        if (en_i && |dirty_q) state_d = S_SCAN;
      end
      S_SCAN: begin
        page_d             = scan_page;
        dirty_d[scan_page] = 1'b0;
        inv_d              = invert_i;
        cmd_d              = '0;
        ind_d              = '0;
        clm_d              = '0;
        state_d            = S_CMD;
      end
      S_CMD: begin
        dc_d     = 1'b0;
        spi_en_d = 1'b1;
        case (cmd_q)
          2'd0:    spi_data_d = 8'h22;
          2'd1:    spi_data_d = 8'(page_q);
          2'd2:    spi_data_d = 8'h00;
          default: spi_data_d = 8'h10;
        endcase
        state_d = S_CMD_WAIT;
      end
      S_CMD_WAIT: begin
        if (spi_fin_i) begin
          spi_en_d = 1'b0;
          state_d  = S_GAP;
          if (cmd_q != 2'd3) begin
            cmd_d = cmd_q + 2'd1;
            ret_d = S_CMD;
          end else begin
            ret_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        rom_addr_d = {fb_q[page_q][ind_q], clm_q};
        rom_en_d   = 1'b1;
        state_d    = S_ROM_WAIT;
      end
      S_ROM_WAIT: begin
        state_d = S_DATA;
      end
      S_DATA: begin
        spi_data_d = rom_data_i ^ {8{inv_q}};
        dc_d       = 1'b1;
        spi_en_d   = 1'b1;
        state_d    = S_DATA_WAIT;
      end
      S_DATA_WAIT: begin
        if (spi_fin_i) begin
          spi_en_d = 1'b0;
          ret_d    = S_NEXT;
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        // Holding off until fin falls keeps the next request from overlapping it.
        if (!spi_fin_i) state_d = ret_q;
      end
      S_NEXT: begin
        if (clm_q != LAST_CLM) begin
          clm_d   = clm_q + 1'b1;
          state_d = S_FETCH;
        end else begin
          clm_d = '0;
          if (ind_q != LAST_IND) begin
            ind_d   = ind_q + 1'b1;
            state_d = S_FETCH;
          end else if (en_i && |dirty_q) begin
            state_d = S_SCAN;
          end else begin
            frame_done_d = ~|dirty_q;
            state_d      = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Sets are applied after the render clear so a same-cycle set wins.
    if (full_refresh_i) dirty_d = '1;
    if (wr_ok) dirty_d[wr_page_i] = 1'b1;
  end

  assign rom_en_o     = rom_en_q;
  assign rom_addr_o   = rom_addr_q;
  assign spi_en_o     = spi_en_q;
  assign spi_data_o   = spi_data_q;
  assign dc_o         = dc_q;
  assign busy_o       = (state_q != S_IDLE);
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_oled_text_engine.sv
// tb/tb_oled_text_engine.sv - scoreboard bench for oled_text_engine
module tb_oled_text_engine;

  localparam int SPI_LAT = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, full_refresh, invert, wr_en;
  logic [1:0]  wr_page;
  logic [3:0]  wr_col;
  logic [7:0]  wr_data;
  logic        rom_en;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data = 8'h00;
  logic        spi_en;
  logic [7:0]  spi_data;
  logic        spi_fin = 1'b0;
  logic        dc, busy, frame_done;

  int checks = 0;
  int errors = 0;
  int frames = 0;
  int total_bytes = 0;
  int data_in_page = 0;
  int spi_cnt = 0;
  logic prev_en = 1'b0;
  logic [8:0] snap = '0;
  logic [8:0] sb [$];
  logic [7:0] tb_fb [4][16];

  oled_text_engine dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .full_refresh_i(full_refresh),
    .invert_i(invert), .wr_en_i(wr_en), .wr_page_i(wr_page), .wr_col_i(wr_col),
    .wr_data_i(wr_data), .rom_en_o(rom_en), .rom_addr_o(rom_addr),
    .rom_data_i(rom_data), .spi_en_o(spi_en), .spi_data_o(spi_data),
    .spi_fin_i(spi_fin), .dc_o(dc), .busy_o(busy), .frame_done_o(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_f(input logic [10:0] a);
    logic [7:0] c;
    logic [7:0] k;
    c = a[10:3];
    k = {5'd0, a[2:0]};
    return (c * 8'd13) + (k * 8'd29) + 8'd5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Font ROM: registered read, data valid the cycle after rom_en.
  always @(posedge clk) if (rom_en) rom_data <= rom_f(rom_addr);

  // SPI controller model plus byte scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      spi_cnt = 0;
      spi_fin = 1'b0;
      prev_en = 1'b0;
    end else begin
      if (spi_en && !prev_en) chk("spi_en_rise_fin_low", 32'(spi_fin), 32'd0);
      prev_en = spi_en;
      if (spi_en && !spi_fin) begin
        spi_cnt++;
        if (spi_cnt == 1) snap = {dc, spi_data};
        if (spi_cnt == SPI_LAT) begin
          spi_fin = 1'b1;
          spi_cnt = 0;
          chk("spi_stable", 32'({dc, spi_data}), 32'(snap));
          total_bytes++;
          if (!dc) data_in_page = 0;
          else data_in_page++;
          chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) chk("spi_byte", 32'({dc, spi_data}), 32'(sb.pop_front()));
        end
      end else if (!spi_en) begin
        spi_fin = 1'b0;
      end
    end
    if (frame_done) begin
      frames++;
      chk("frame_done_sb_empty", 32'(sb.size()), 32'd0);
    end
  end

  task automatic push_page(input int p, input bit inv);
    sb.push_back({1'b0, 8'h22});
    sb.push_back({1'b0, 8'(p)});
    sb.push_back({1'b0, 8'h00});
    sb.push_back({1'b0, 8'h10});
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 8; k++) begin
        sb.push_back({1'b1, rom_f({tb_fb[p][i], 3'(k)}) ^ {8{inv}}});
      end
    end
  endtask

  task automatic fb_write(input int p, input int c, input logic [7:0] d);
    tb_fb[p][c] = d;
    @(negedge clk);
    wr_en = 1'b1; wr_page = 2'(p); wr_col = 4'(c); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int i = 0; i < budget && frames < n; i++) @(negedge clk);
    chk("frames_reached", 32'(frames), 32'(n));
  endtask

  task automatic clear_model();
    for (int p = 0; p < 4; p++)
      for (int c = 0; c < 16; c++) tb_fb[p][c] = 8'h00;
  endtask

  initial begin
    int base;
    int fr;
    bit hit;
    clear_model();
    rst_n = 1'b0; en = 1'b0; full_refresh = 1'b0; invert = 1'b0;
    wr_en = 1'b0; wr_page = '0; wr_col = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_spi_en", 32'(spi_en), 32'd0);
    chk("rst_spi_data", 32'(spi_data), 32'd0);
    chk("rst_dc", 32'(dc), 32'd1);
    chk("rst_rom_en", 32'(rom_en), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);

    // Power-up paint of all four pages.
    for (int p = 0; p < 4; p++) push_page(p, 1'b0);
    rst_n = 1'b1;
    en = 1'b1;
    wait_frames(1, 12000);
    repeat (20) @(negedge clk);
    chk("t1_one_frame", 32'(frames), 32'd1);
    chk("t1_idle", 32'(busy), 32'd0);

    // Single character write re-renders only its page.
    fb_write(2, 5, 8'h41);
    push_page(2, 1'b0);
    wait_frames(2, 4000);
    repeat (20) @(negedge clk);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Inverted full refresh.
    invert = 1'b1;
    @(negedge clk);
    full_refresh = 1'b1;
    @(negedge clk);
    full_refresh = 1'b0;
    for (int p = 0; p < 4; p++) push_page(p, 1'b1);
    wait_frames(3, 12000);
    invert = 1'b0;
    repeat (20) @(negedge clk);

    // Write into page 1 while its data byte 60 is in flight; col 10 is fetched later.
    tb_fb[1][10] = 8'h5A;
    fb_write(1, 0, 8'h33);
    push_page(1, 1'b0);
    push_page(1, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 4000 && !hit; i++) begin
      @(negedge clk);
      if (spi_en && dc && data_in_page == 60) hit = 1'b1;
    end
    chk("t4_byte60_seen", 32'(hit), 32'd1);
    fb_write(1, 10, 8'h5A);
    wait_frames(4, 8000);
    repeat (30) @(negedge clk);
    chk("t4_one_frame", 32'(frames), 32'd4);
    chk("t4_idle", 32'(busy), 32'd0);

    // Drop en during page 0 with the rest still dirty.
    fr = frames;
    push_page(0, 1'b0);
    base = total_bytes;
    @(negedge clk);
    full_refresh = 1'b1;
    @(negedge clk);
    full_refresh = 1'b0;
    for (int i = 0; i < 4000 && total_bytes < base + 6; i++) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 4000 && busy; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    chk("t5_idle", 32'(busy), 32'd0);
    chk("t5_no_frame", 32'(frames), 32'(fr));
    chk("t5_page0_done", 32'(sb.size()), 32'd0);
    for (int p = 1; p < 4; p++) push_page(p, 1'b0);
    en = 1'b1;
    wait_frames(fr + 1, 10000);

    // Asynchronous reset in the middle of a data byte.
    fr = frames;
    push_page(0, 1'b0);
    base = total_bytes;
    @(negedge clk);
    full_refresh = 1'b1;
    @(negedge clk);
    full_refresh = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 4000 && !hit; i++) begin
      @(negedge clk);
      if (spi_en && dc && total_bytes >= base + 10) hit = 1'b1;
    end
    chk("t6_data_wait_seen", 32'(hit), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_spi_en_drop", 32'(spi_en), 32'd0);
    chk("t6_busy_drop", 32'(busy), 32'd0);
    chk("t6_dc_reset", 32'(dc), 32'd1);
    sb.delete();
    en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    repeat (20) @(negedge clk);
    chk("t6_held_idle", 32'(busy), 32'd0);
    for (int p = 0; p < 4; p++) push_page(p, 1'b0);
    en = 1'b1;
    wait_frames(fr + 1, 12000);
    repeat (20) @(negedge clk);
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
